// File: rtl/iter_compare_unit.sv
// iter_compare_unit
//   Registered execute-stage comparator. It handles set-less-than, conditional
//   moves and branch/trap conditions, which resolve in one cycle. CLO and CLZ
//   use an iterative engine that scans BPC bits per cycle, MSB first, and stops
//   at the first chunk that does not match completely.
//
// State table:
//   state   | meaning
//   S_IDLE  | ready to accept an operation (in_ready=1)
//   S_COUNT | CLO/CLZ scan in progress, one BPC-bit chunk per cycle
//   S_DONE  | result valid (out_valid=1); outputs frozen until out_ready
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous abort; returns to IDLE and clears the outputs
//   in_valid/ready  operation handshake (op, a, b)
//   out_valid/ready result handshake (res, res_we, cond, cond_u)
module iter_compare_unit #(
    parameter int WIDTH = 32,
    parameter int BPC   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             res_we,
    output logic             cond,
    output logic             cond_u
);

    localparam int NCHUNK = WIDTH / BPC;
    localparam int CIW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CW     = $clog2(WIDTH + 1);
    localparam int LW     = $clog2(BPC + 1);

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] scan;
    logic             is_clo;
    logic [CW-1:0]    cnt;
    logic [CIW-1:0]   chunk_idx;

    logic             accept, is_count_op, last_chunk, chunk_full, stop;
    logic [BPC-1:0]   chunk_m;
    logic [LW-1:0]    lead;
    logic [CW-1:0]    cnt_sum;

    logic             slt_s, slt_u, a_zero, b_zero, neg;
    logic [WIDTH-1:0] cmp_res;
    logic             cmp_we, cmp_c, cmp_cu;

    assign accept      = (state == S_IDLE) && in_valid && !flush;
    assign is_count_op = (op == 4'd4) || (op == 4'd5);

    // Invert the chunk for CLZ so both ops reduce to counting leading ones.
    always_comb begin
        chunk_m = is_clo ? scan[WIDTH-1 -: BPC] : ~scan[WIDTH-1 -: BPC];
        lead    = '0;
        stop    = 1'b0;
        for (int i = BPC - 1; i >= 0; i--) begin
            if (!stop && chunk_m[i]) lead = lead + 1'b1;
            else                     stop = 1'b1;
        end
    end

    assign chunk_full = (lead == LW'(BPC));
    assign last_chunk = (chunk_idx == CIW'(NCHUNK - 1));
    assign cnt_sum    = cnt + CW'(lead);

    // Single-cycle ops, evaluated on the live inputs at the accepting edge.
    always_comb begin
        slt_s   = $signed(a) < $signed(b);
        slt_u   = a < b;
        a_zero  = (a == '0);
        b_zero  = (b == '0);
        neg     = a[WIDTH-1];
        cmp_res = '0;
        cmp_we  = 1'b0;
        cmp_c   = 1'b0;
        case (op)
            4'd0, 4'd2: begin cmp_res = {{(WIDTH-1){1'b0}}, slt_s}; cmp_we = 1'b1; end
            4'd1, 4'd3: begin cmp_res = {{(WIDTH-1){1'b0}}, slt_u}; cmp_we = 1'b1; end
            4'd6:  begin cmp_res = a; cmp_we = b_zero;  cmp_c = b_zero;  end
            4'd13: begin cmp_res = a; cmp_we = !b_zero; cmp_c = !b_zero; end
            4'd7:  cmp_c = !neg;
            4'd8:  cmp_c = (a == b);
            4'd9:  cmp_c = neg;
            4'd10: cmp_c = !neg && !a_zero;
            4'd11: cmp_c = neg || a_zero;
            4'd12: cmp_c = (a != b);
            4'd14: cmp_c = !slt_s;
            4'd15: cmp_c = slt_s;
            default: ;
        endcase
        if (op == 4'd14)      cmp_cu = !slt_u;
        else if (op == 4'd15) cmp_cu = slt_u;
        else                  cmp_cu = cmp_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = is_count_op ? S_COUNT : S_DONE;
            S_COUNT: if (!(chunk_full && !last_chunk)) state_nx = S_DONE;
            S_DONE:  if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (flush) state_nx = S_IDLE;
    end

    always_comb begin
        in_ready  = (state == S_IDLE) && rst_n;
        out_valid = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan      <= '0;
            is_clo    <= 1'b0;
            cnt       <= '0;
            chunk_idx <= '0;
            res       <= '0;
            res_we    <= 1'b0;
            cond      <= 1'b0;
            cond_u    <= 1'b0;
        end else if (flush) begin
            scan      <= '0;
            cnt       <= '0;
            chunk_idx <= '0;
            res       <= '0;
            res_we    <= 1'b0;
            cond      <= 1'b0;
            cond_u    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (is_count_op) begin
                            scan      <= a;
                            is_clo    <= (op == 4'd4);
                            cnt       <= '0;
                            chunk_idx <= '0;
                            res       <= '0;
                            res_we    <= 1'b0;
                            cond      <= 1'b0;
                            cond_u    <= 1'b0;
                        end else begin
                            res    <= cmp_res;
                            res_we <= cmp_we;
                            cond   <= cmp_c;
                            cond_u <= cmp_cu;
                        end
                    end
                end
                S_COUNT: begin
                    if (chunk_full && !last_chunk) begin
                        cnt       <= cnt_sum;
                        scan      <= scan << BPC;
                        chunk_idx <= chunk_idx + 1'b1;
                    end else begin
                        res    <= WIDTH'(cnt_sum);
                        res_we <= 1'b1;
                        cond   <= 1'b0;
                        cond_u <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/iter_compare_unit.md
Name: iter_compare_unit

Overview:
- Registered, parametrised successor to the combinational ALU comparator, with a valid/ready handshake on both sides.
- Covers set-less-than, CLO/CLZ, conditional moves, and branch/trap condition evaluation for the execute stage.
- CLO/CLZ run in an iterative engine that scans BPC bits per cycle and stops early, which removes the long combinational count chain.
- Sits between operand read and writeback/branch resolution.

Parameters:
- WIDTH, 32: operand and result width; must be a multiple of BPC.
- BPC, 4: bits examined per cycle by the CLO/CLZ engine; must be a power of two, 1 to WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort of any operation in flight
- in_valid  in  1  operands and op are valid
- in_ready  out  1  unit can accept an operation
- op  in  4  operation code (see Behaviour)
- a  in  WIDTH  rs operand
- b  in  WIDTH  rt operand, or an already-extended immediate
- out_valid  out  1  result is valid
- out_ready  in  1  consumer takes the result
- res  out  WIDTH  destination value
- res_we  out  1  destination must be written
- cond  out  1  branch/trap condition; signed form for ops 14 and 15
- cond_u  out  1  unsigned form for ops 14 and 15; equals cond for every other op

Behaviour:
- Reset: asynchronous on rst_n low.
  - State goes to IDLE.
  - in_ready=0 while rst_n is low and 1 after release.
  - out_valid, res, res_we, cond, cond_u all 0.
  - An operation in flight is discarded.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - COUNT: CLO/CLZ scan.
  - DONE: out_valid=1, outputs held stable until out_ready.
  - in_ready=0 in COUNT and DONE; there is no overlap between operations.
- IDLE, on in_valid and no flush:
  - Capture op, a and b.
  - Ops 4 and 5 go to COUNT; all other ops compute and go to DONE on the same edge.
- Latency:
  - Non-count ops: out_valid rises 1 cycle after acceptance.
- COUNT:
  - Each cycle examines the next BPC-bit chunk, MSB first.
  - The match bit is 1 for CLO and 0 for CLZ.
  - Chunk fully matching and not the last chunk: add BPC to the count and stay in COUNT.
  - Otherwise: add the number of leading matching bits within the chunk and go to DONE.
  - Count cycles c = min(n/BPC + 1, WIDTH/BPC), where n is the final count (integer division).
  - out_valid rises c+1 cycles after acceptance.
  - The count is zero-extended into res; res_we=1, cond=cond_u=0.
- DONE: on out_ready, go to IDLE on the next edge; in_ready returns 1 in that next cycle.
- flush:
  - Priority over everything except rst_n.
  - In any state, the next state is IDLE and outputs clear as on reset.
  - In IDLE, flush blocks acceptance even if in_valid is high.
- Op table (s = signed compare, u = unsigned compare):
  - 0 SLT and 2 SLTI: res = s(a<b), res_we=1.
  - 1 SLTU and 3 SLTIU: res = u(a<b), res_we=1.
  - 4 CLO and 5 CLZ: as described under COUNT.
  - 6 MOVZ: res=a, res_we=cond=(b==0).
  - 13 MOVN: res=a, res_we=cond=(b!=0).
  - 7 GEZ: cond = s(a>=0).
  - 8 EQ: cond = (a==b).
  - 9 LTZ: cond = s(a<0).
  - 10 GTZ: cond = s(a>0).
  - 11 LEZ: cond = s(a<=0).
  - 12 NE: cond = (a!=b).
  - 14 GE: cond = s(a>=b), cond_u = u(a>=b).
  - 15 LT: cond = s(a<b), cond_u = u(a<b).
  - For ops 7-12, 14 and 15: res=0, res_we=0.
  - For the set-less-than ops (0-3): cond=cond_u=0.
  - For MOVZ/MOVN with a false condition: res still equals a, and res_we=0.
- Arithmetic: the signed compare treats bit WIDTH-1 as the sign; there are no width-extension side effects.
- Boundaries:
  - CLZ of 0 and CLO of all ones both return WIDTH after WIDTH/BPC count cycles.
  - out_ready held low keeps DONE and all outputs frozen indefinitely.
  - Input changes outside acceptance have no effect.

Test Plan:
- Compare, WIDTH=32: SLT a=0xFFFFFFFF b=1 -> res=1. SLTU with the same operands -> res=0. out_valid 1 cycle after acceptance, res_we=1.
- CLZ, WIDTH=32, BPC=4: a=0x00000000 -> res=32 with out_valid 9 cycles after acceptance. a=0x00F00000 -> res=8 with out_valid 4 cycles after acceptance.
- CLO, BPC=4: a=0xF7000000 -> res=4 with out_valid 3 cycles after acceptance. Repeat with BPC=1 -> res=4 with out_valid 6 cycles after acceptance.
- Cond move and compare:
  - MOVZ a=0x1234 b=0 -> res=0x1234, res_we=1.
  - MOVN a=0x1234 b=0 -> res_we=0, cond=0.
  - op 14 a=0x80000000 b=1 -> cond=0, cond_u=1.
  - op 15 with the same operands -> cond=1, cond_u=0.
- Backpressure: hold out_ready=0 for 5 cycles after a BGTZ with a=5 -> cond=1 stable and in_ready=0 throughout. Release out_ready -> in_ready=1 on the following cycle.
- Abort:
  - Assert flush in the 2nd cycle of CLZ a=0 -> IDLE next cycle, out_valid never rises.
  - Repeat with rst_n pulsed low instead -> outputs 0 immediately, with no clock edge needed.
